// File: rtl/dfe_pkg.sv
// Shared types and the slicer-decision decoder for the DFE ISI canceller.
package dfe_pkg;

  localparam int FB_W = 40;

  typedef enum logic [1:0] {IDLE, MAC, EMIT, WAIT_FB} dfe_state_t;

  typedef logic signed [2:0] dfe_sym_t;

  // Map a slicer decision back to its PAM4 symbol code (+3/+1/-1/-3).
  function automatic dfe_sym_t fb_to_sym(input logic signed [FB_W-1:0] feedback,
                                         input logic signed [FB_W-1:0] sep);
    dfe_sym_t sym;
    if (feedback >= sep)       sym = 3'sd3;
    else if (feedback >= 0)    sym = 3'sd1;
    else if (feedback >= -sep) sym = -3'sd1;
    else                       sym = -3'sd3;
    return sym;
  endfunction

endpackage

// File: rtl/dfe_tap_mac.sv
// Post-cursor tap products (registered on en) followed by a combinational adder tree.
module dfe_tap_mac
  import dfe_pkg::*;
#(
  parameter int NUM_TAPS   = 4,
  parameter int COEF_WIDTH = 8,
  parameter int ISI_W      = COEF_WIDTH + 2 + $clog2(NUM_TAPS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic [NUM_TAPS-1:0][COEF_WIDTH-1:0] coef,
  input  dfe_sym_t [NUM_TAPS-1:0]             hist,
  output logic signed [ISI_W-1:0]             isi
);

  // |coef * sym| <= 2^(COEF_WIDTH-1) * 3, so two extra bits hold any product.
  localparam int PW = COEF_WIDTH + 2;

  logic signed [PW-1:0] prod [NUM_TAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '{default: '0};
    end else if (en) begin
      for (int k = 0; k < NUM_TAPS; k++)
        prod[k] <= PW'($signed(coef[k])) * PW'($signed(hist[k]));
    end
  end

  always_comb begin
    isi = '0;
    for (int k = 0; k < NUM_TAPS; k++)
      isi = isi + ISI_W'(prod[k]);
  end

endmodule

// File: rtl/dfe_isi_canceller.sv
// Decision-feedback ISI canceller: one symbol in flight, loop closed through the slicer.
// Optional output clamp to +/-2^(SIGNAL_RESOLUTION+1) enabled by defining DFE_ISI_SAT_EN.
module dfe_isi_canceller
  import dfe_pkg::*;
#(
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int PULSE_RESPONSE_LENGTH = 5,
  parameter int NUM_TAPS              = 4,
  parameter int COEF_WIDTH            = 8,
  parameter int SYMBOL_SEPERATION     = 56
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic signed [SIGNAL_RESOLUTION-1:0]                    sample_in,
  input  logic                                                   s_valid,
  output logic                                                   s_ready,
  output logic signed [SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH-1:0] estimation,
  output logic                                                   e_valid,
  input  logic signed [FB_W-1:0]                                 feedback_value,
  input  logic                                                   f_valid,
  input  logic                                                   coef_wr,
  input  logic [$clog2(NUM_TAPS)-1:0]                            coef_addr,
  input  logic signed [COEF_WIDTH-1:0]                           coef_data,
  output logic [31:0]                                            sym_count
);

  localparam int EW    = SIGNAL_RESOLUTION * PULSE_RESPONSE_LENGTH;
  localparam int ISI_W = COEF_WIDTH + 2 + $clog2(NUM_TAPS);

  dfe_state_t                          state, nxt;
  logic signed [SIGNAL_RESOLUTION-1:0] sample_q;
  logic [NUM_TAPS-1:0][COEF_WIDTH-1:0] coef_q;
  dfe_sym_t [NUM_TAPS-1:0]             hist;
  logic signed [ISI_W-1:0]             isi;
  logic signed [EW-1:0]                diff;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (s_valid) nxt = MAC;
      MAC:     nxt = EMIT;
      EMIT:    nxt = WAIT_FB;
      WAIT_FB: if (f_valid) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state == IDLE) && !rst;
    e_valid = (state == EMIT) && !rst;
  end

  // hist[0] is the newest decision; capture shifts older ones up one tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q  <= '0;
      coef_q    <= '0;
      hist      <= '0;
      sym_count <= '0;
    end else begin
      if (coef_wr && int'(coef_addr) < NUM_TAPS)
        coef_q[coef_addr] <= coef_data;
      if (state == IDLE && s_valid)
        sample_q <= sample_in;
      if (state == WAIT_FB && f_valid) begin
        hist      <= {hist[NUM_TAPS-2:0],
                      fb_to_sym(feedback_value, FB_W'(SYMBOL_SEPERATION))};
        sym_count <= sym_count + 32'd1;
      end
    end
  end

  dfe_tap_mac #(
    .NUM_TAPS  (NUM_TAPS),
    .COEF_WIDTH(COEF_WIDTH),
    .ISI_W     (ISI_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .en  (state == MAC),
    .coef(coef_q),
    .hist(hist),
    .isi (isi)
  );

  // Sample and products are both held in registers, so the result is stable through EMIT.
  assign diff = EW'(sample_q) - EW'(isi);

`ifdef DFE_ISI_SAT_EN
  localparam logic signed [EW-1:0] SAT_HI = EW'((1 << (SIGNAL_RESOLUTION + 1)) - 1);
  localparam logic signed [EW-1:0] SAT_LO = ~SAT_HI;

  always_comb begin
    if (diff > SAT_HI)      estimation = SAT_HI;
    else if (diff < SAT_LO) estimation = SAT_LO;
    else                    estimation = diff;
  end
`else
  assign estimation = diff;
`endif

endmodule

// File: tb/tb_dfe_isi_canceller.sv
// Randomised bench for dfe_isi_canceller against a transaction-level DFE model.
module tb_dfe_isi_canceller;

  localparam int SR = 8, PRL = 5, NT = 4, CW = 8, SEP = 56, EW = SR * PRL;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [SR-1:0] sample_in = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [EW-1:0] estimation;
  logic                 e_valid;
  logic signed [39:0]   feedback_value = '0;
  logic                 f_valid = 1'b0;
  logic                 coef_wr = 1'b0;
  logic [1:0]           coef_addr = '0;
  logic signed [CW-1:0] coef_data = '0;
  logic [31:0]          sym_count;

  dfe_isi_canceller #(
    .SIGNAL_RESOLUTION(SR), .PULSE_RESPONSE_LENGTH(PRL), .NUM_TAPS(NT),
    .COEF_WIDTH(CW), .SYMBOL_SEPERATION(SEP)
  ) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .s_valid(s_valid), .s_ready(s_ready),
    .estimation(estimation), .e_valid(e_valid), .feedback_value(feedback_value),
    .f_valid(f_valid), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // model state
  int          coef_m [NT];
  int          hist_m [NT];
  int unsigned cnt_m;

  // per-cycle expectations, written by the driver, checked at negedge
  bit          chk_en = 1'b0, chk_cnt = 1'b0, chk_est = 1'b0, lit_en = 1'b0;
  bit          exp_rdy, exp_ev;
  longint      exp_est, lit_val;
  int unsigned exp_cnt;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_ready", longint'(s_ready), longint'(exp_rdy));
      chk("e_valid", longint'(e_valid), longint'(exp_ev));
      if (chk_cnt) chk("sym_count", longint'(sym_count), longint'(exp_cnt));
      if (exp_ev || chk_est) chk("estimation", longint'(estimation), exp_est);
      if (lit_en) chk("estimation_literal", longint'(estimation), lit_val);
    end
  end

  function automatic int sym_of(input longint f);
    if (f >= SEP)  return 3;
    if (f >= 0)    return 1;
    if (f >= -SEP) return -1;
    return -3;
  endfunction

  function automatic longint est_model(input int s);
    longint isi = 0;
    longint d;
    for (int k = 0; k < NT; k++) isi += longint'(coef_m[k] * hist_m[k]);
    d = longint'(s) - isi;
`ifdef DFE_ISI_SAT_EN
    if (d > (1 << (SR + 1)) - 1) d = (1 << (SR + 1)) - 1;
    if (d < -(1 << (SR + 1)))    d = -(1 << (SR + 1));
`endif
    return d;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit rdy, input bit ev);
    exp_rdy = rdy; exp_ev = ev; exp_cnt = cnt_m;
    chk_cnt = 1'b1; chk_est = 1'b0; lit_en = 1'b0;
  endtask

  // f_valid/feedback noise outside WAIT_FB must have no effect
  task automatic idle_inputs();
    s_valid = 1'b0; coef_wr = 1'b0;
    f_valid = 1'($urandom_range(0, 1));
    feedback_value = 40'($urandom);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(); idle_inputs(); rst = 1'b1; set_exp(1'b0, 1'b0); chk_cnt = 1'b0;
      chk_en = 1'b1;
    end
    for (int k = 0; k < NT; k++) begin coef_m[k] = 0; hist_m[k] = 0; end
    cnt_m = 0;
    cyc(); idle_inputs(); rst = 1'b0; set_exp(1'b1, 1'b0); chk_est = 1'b1; exp_est = 0;
  endtask

  task automatic wr_coef(input int a, input int d);
    cyc(); idle_inputs();
    coef_wr = 1'b1; coef_addr = 2'(a); coef_data = CW'(d);
    set_exp(1'b1, 1'b0);
    coef_m[a] = d;
  endtask

  task automatic do_symbol(input int s, input longint f, input int dly, input bit mac_wr,
                           input int wa, input int wd, input bit use_lit, input longint lit,
                           input bit abort);
    longint e;
    cyc(); idle_inputs(); s_valid = 1'b1; sample_in = SR'(s); set_exp(1'b1, 1'b0);
    // MAC: a write here must not affect this symbol
    cyc(); idle_inputs(); s_valid = 1'($urandom_range(0, 1)); sample_in = SR'($urandom);
    set_exp(1'b0, 1'b0);
    e = est_model(s);
    if (mac_wr) begin
      coef_wr = 1'b1; coef_addr = 2'(wa); coef_data = CW'(wd); coef_m[wa] = wd;
    end
    cyc(); idle_inputs(); s_valid = 1'($urandom_range(0, 1)); set_exp(1'b0, 1'b1);
    exp_est = e;
    if (use_lit) begin lit_en = 1'b1; lit_val = lit; end
    for (int i = 0; i < dly; i++) begin
      cyc(); idle_inputs(); f_valid = 1'b0; s_valid = 1'($urandom_range(0, 1));
      set_exp(1'b0, 1'b0);
    end
    if (abort) begin
      do_reset();
      return;
    end
    cyc(); idle_inputs(); f_valid = 1'b1; feedback_value = f[39:0]; set_exp(1'b0, 1'b0);
    for (int k = NT - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = sym_of(f);
    cnt_m++;
  endtask

  longint bl [8] = '{56, 55, 0, -1, -56, -57, 57, -55};

  initial begin
    int s, dly, wa, wd;
    longint f;
    bit mac_wr, abort;

    do_reset();
    do_symbol(50, 0, 0, 0, 0, 0, 1, 50, 0);

    do_reset();
    wr_coef(0, 10);
    do_symbol(100, 84, 0, 0, 0, 0, 1, 100, 0);
    do_symbol(50, -10, 0, 0, 0, 0, 1, 20, 0);

    do_reset();
    wr_coef(0, 10); wr_coef(1, 5);
    do_symbol(0, 100, 0, 0, 0, 0, 1, 0, 0);
    do_symbol(0, -20, 0, 0, 0, 0, 1, -30, 0);
    do_symbol(0, 0, 0, 0, 0, 0, 1, -5, 0);
    do_symbol(7, 0, 5, 0, 0, 0, 1, 2, 0);          // f_valid held low for 5 cycles
    do_symbol(20, 56, 0, 1, 0, -50, 1, 5, 0);      // write during MAC uses old coef
    do_symbol(20, 55, 0, 0, 0, 0, 1, 165, 0);
    do_symbol(0, -1, 0, 0, 0, 0, 0, 0, 0);
    do_symbol(0, -56, 0, 0, 0, 0, 0, 0, 0);
    do_symbol(0, -57, 0, 0, 0, 0, 0, 0, 0);
    wr_coef(0, 1); wr_coef(1, 8); wr_coef(2, 64); wr_coef(3, 0);
    do_symbol(0, 0, 0, 0, 0, 0, 1, 75, 0);

    do_symbol(9, 0, 2, 0, 0, 0, 0, 0, 1);          // reset mid-WAIT_FB
    wr_coef(0, 10); wr_coef(1, 7);
    do_symbol(30, 100, 0, 0, 0, 0, 1, 30, 0);

    do_reset();
    wr_coef(0, -128); wr_coef(1, -116);
    do_symbol(0, 10, 0, 0, 0, 0, 1, 0, 0);
    do_symbol(0, 100, 0, 0, 0, 0, 1, 128, 0);
`ifdef DFE_ISI_SAT_EN
    do_symbol(127, 0, 0, 0, 0, 0, 1, 511, 0);
`else
    do_symbol(127, 0, 0, 0, 0, 0, 1, 627, 0);
`endif

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0)
        wr_coef(int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 255)) - 128);
      s = int'($urandom_range(0, 255)) - 128;
      case ($urandom_range(0, 3))
        0: f = bl[$urandom_range(0, 7)];
        1: f = longint'($urandom_range(0, 400)) - 200;
        2: begin f = {$urandom, $urandom}; f = f >>> 24; end
        default: f = longint'($urandom_range(0, 60)) - 30;
      endcase
      dly    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, 3));
      mac_wr = ($urandom_range(0, 3) == 0);
      wa     = int'($urandom_range(0, NT - 1));
      wd     = int'($urandom_range(0, 255)) - 128;
      abort  = ($urandom_range(0, 39) == 0);
      do_symbol(s, f, dly, mac_wr, wa, wd, 1'b0, 0, abort);
    end

    cyc(); idle_inputs(); set_exp(1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dfe_isi_canceller.md
# dfe_isi_canceller

Decision-feedback ISI canceller for the Rx simulation path. It accepts raw received PAM4 samples and subtracts the post-cursor ISI predicted from previously decided symbols. It presents the resulting estimation to the PAM4 slicer (`decision_maker_prl`), then captures the slicer's `feedback_value` into a symbol-history shift register. The block sits directly upstream of the slicer and closes the DFE loop with it, one symbol in flight at a time.

## Interface
- `SIGNAL_RESOLUTION`, 8: width of signed `sample_in`.
- `PULSE_RESPONSE_LENGTH`, 5: pulse response length; estimation width is `SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH`.
- `NUM_TAPS`, 4: post-cursor taps; must equal `PULSE_RESPONSE_LENGTH-1`.
- `COEF_WIDTH`, 8: signed tap coefficient width.
- `SYMBOL_SEPERATION`, 56: slicer level spacing, used to decode feedback.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `sample_in`  in  `SIGNAL_RESOLUTION`  signed received sample.
- `s_valid`  in  1  `sample_in` valid.
- `s_ready`  out  1  block can accept a sample.
- `estimation`  out  `SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH`  signed ISI-cancelled sample to the slicer.
- `e_valid`  out  1  one-cycle strobe, estimation valid.
- `feedback_value`  in  40  signed slicer decision.
- `f_valid`  in  1  slicer decision valid; treated as a level signal.
- `coef_wr`  in  1  coefficient write strobe.
- `coef_addr`  in  `$clog2(NUM_TAPS)`  tap index; 0 = first post-cursor.
- `coef_data`  in  `COEF_WIDTH`  signed coefficient.
- `sym_count`  out  32  number of decisions captured; wraps at 2^32.

## Operation
- Symbol code decoded from `feedback_value` (F), with S = `SYMBOL_SEPERATION`:
  - F >= S → +3
  - 0 <= F < S → +1
  - -S <= F < 0 → -1
  - F < -S → -3
- History `d[0..NUM_TAPS-1]`: signed 3-bit codes, `d[0]` is the newest. On capture, `d[k] <= d[k-1]` and `d[0] <= new code`.
- ISI = Σ `coef[k]*d[k]`, computed at full precision (`COEF_WIDTH+2+$clog2(NUM_TAPS)` bits).
- `estimation` = sext(`sample_in`) − sext(ISI).
- FSM states and transitions:
  - **IDLE**: `s_ready`=1. `s_valid` latches the sample and moves to MAC.
  - **MAC**: products registered → EMIT.
  - **EMIT**: `estimation` registered, `e_valid`=1 → WAIT_FB.
  - **WAIT_FB**: if `f_valid`, decode and shift history, `sym_count`++, → IDLE. Otherwise hold in WAIT_FB indefinitely.
- `s_ready` is 0 in every state except IDLE.
- Coefficient writes:
  - Accepted in any state and take effect at the next MAC cycle.
  - A write in the same cycle as MAC is not seen by that MAC; it uses the old value.
  - Writes with `coef_addr` >= `NUM_TAPS` are ignored.
- Reset:
  - Forces IDLE from any state, including mid-WAIT_FB; any in-flight symbol is dropped.
  - Clears history (d=0, so no ISI), coefficients, `estimation`=0, `e_valid`=0, `sym_count`=0.
  - `s_ready`=0 while `rst` is high and 1 in the first cycle after release.

## Timing
- Cycle 0: `s_valid && s_ready`.
- Cycle 1: MAC.
- Cycle 2: `e_valid`=1 and `estimation` valid.
- Cycle 3: slicer output visible (1-cycle slicer latency); feedback sampled at the end of cycle 3.
- Cycle 4: IDLE, `s_ready`=1.
- Throughput: 1 symbol per 4 cycles when `f_valid` is ready.
- `e_valid` is exactly one cycle per accepted sample and never asserts outside EMIT.
- `f_valid` is ignored outside WAIT_FB. The slicer holds it high after its first decision, so it must not be treated as a pulse.

## Configuration
- `DFE_ISI_SAT_EN` defined: `estimation` is clamped to [−2^(SIGNAL_RESOLUTION+1), 2^(SIGNAL_RESOLUTION+1)−1], i.e. [−512, 511] at default parameters.
- `DFE_ISI_SAT_EN` undefined: full-width sign-extended difference, with no clamping.

## Structure
- Package `dfe_pkg` holds:
  - state enum `dfe_state_t` (IDLE/MAC/EMIT/WAIT_FB)
  - `typedef logic signed [2:0] dfe_sym_t`
  - function `fb_to_sym(feedback, sep)`
- Sub-module `dfe_tap_mac` (coefficient × history products, registered, plus adder tree) is natural. FSM, history, and coefficient file stay in the top.

## Test plan
- Reset release → `estimation`=0, `e_valid`=0, `sym_count`=0, `s_ready`=1 in the first cycle after `rst` falls.
- All coefficients 0, `sample_in`=50 → `estimation`=50 with `e_valid` in cycle 2 only; `s_ready` returns in cycle 4.
- `coef[0]`=10; sample 100 → estimation 100, slicer F=84 captured as d=+3; next sample 50 → estimation 20.
- Coefficients {10,5,0,0}; decisions +3 then −1; third sample 0 → ISI=10·(−1)+5·3=5, estimation −5.
- `f_valid` held 0 after EMIT → stays in WAIT_FB with `s_ready`=0 and no `sym_count` change. Raising `f_valid` → captured and IDLE next cycle.
- `rst` pulsed during WAIT_FB → IDLE, history cleared. Next sample 30 with `coef[0]`=0 after reload → estimation 30.
- With `DFE_ISI_SAT_EN` defined: `sample_in`=127, ISI=−500 → estimation 511.
